// File: rtl/l2_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// l2_arbiter_pkg
// Shared types and constants for the L2 port arbiter:
//   ADDR_W / LINE_W / SEL_W : line address, line data and byte-select widths
//   DEF_CNT_W               : default width of the conflict counter
//   arb_state_t             : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   grant_t                 : which side won the most recent tie
//   arb_req_t               : one latched request (we, adr, sel, dat_m)
//   pack_req()              : builds an arb_req_t from loose request fields
// ---------------------------------------------------------------------------
package l2_arbiter_pkg;

    localparam int ADDR_W    = 12;
    localparam int LINE_W    = 128;
    localparam int SEL_W     = 16;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [SEL_W-1:0]  sel;
        logic [LINE_W-1:0] dat_m;
    } arb_req_t;

    function automatic arb_req_t pack_req(
        input logic              we,
        input logic [ADDR_W-1:0] adr,
        input logic [SEL_W-1:0]  sel,
        input logic [LINE_W-1:0] dat_m
    );
        arb_req_t r;
        r.we    = we;
        r.adr   = adr;
        r.sel   = sel;
        r.dat_m = dat_m;
        return r;
    endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// ---------------------------------------------------------------------------
// l2_arbiter_if
// One line-wide wishbone-style link (used for the I miss port, the D miss
// port and the shared L2 port).
//   cyc, stb, we, adr, sel, dat_m : driven by the master
//   ack, dat_s                    : driven by the slave
// Modports: master (issues requests), slave (answers them).
// ---------------------------------------------------------------------------
interface l2_arbiter_if;

    logic                              cyc;
    logic                              stb;
    logic                              we;
    logic [l2_arbiter_pkg::ADDR_W-1:0] adr;
    logic [l2_arbiter_pkg::SEL_W-1:0]  sel;
    logic [l2_arbiter_pkg::LINE_W-1:0] dat_m;
    logic                              ack;
    logic [l2_arbiter_pkg::LINE_W-1:0] dat_s;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  ack, dat_s
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output ack, dat_s
    );

endinterface

// File: rtl/l2_arbiter_rr.sv
// ---------------------------------------------------------------------------
// l2_arbiter_rr
// Two-way round-robin grant for the I and D requesters.
//   clk, rst         : clock, synchronous active-high reset
//   arb_en           : arbitration allowed this cycle (port is idle)
//   i_req, d_req     : live requests
//   grant_i, grant_d : one-hot grant (both 0 when nothing is granted)
//   conflict         : both sides requested while arbitration was open
// The remembered winner only moves on a tie; an uncontested grant leaves it
// alone, so the next tie goes to whoever lost (or did not win) the last one.
// It resets to D so that I wins the first tie.
// ---------------------------------------------------------------------------
module l2_arbiter_rr
    import l2_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d,
    output logic conflict
);

    grant_t last_grant_reg;

    assign conflict = arb_en & i_req & d_req;
    assign grant_i  = arb_en & i_req & (~d_req | (last_grant_reg == GRANT_D));
    assign grant_d  = arb_en & d_req & (~i_req | (last_grant_reg == GRANT_I));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= GRANT_D;
        end else if (conflict) begin
            last_grant_reg <= grant_i ? GRANT_I : GRANT_D;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// ---------------------------------------------------------------------------
// l2_arbiter
// Shares the single L2 line port between the I-cache and D-cache miss ports.
// A request is latched when granted, presented to the L2 from the latch until
// l2 ack, and the ack/read data are steered back to the owner only.
//   clk, rst        : clock, synchronous active-high reset
//   i_bus, d_bus    : slave links from the I and D caches (req = cyc & stb)
//   l2_bus          : master link to the L2
//   clear_cnt       : synchronous clear of conflict_count (beats increment)
//   conflict_count  : saturating count of idle cycles with both requests up
// Every output is forced to 0 while rst is high, so a reset in the middle of a
// transaction drops l2 cyc at once; the L2 has to discard that operation.
// ---------------------------------------------------------------------------
module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
)
(
    input  logic             clk,
    input  logic             rst,
    l2_arbiter_if.slave      i_bus,
    l2_arbiter_if.slave      d_bus,
    l2_arbiter_if.master     l2_bus,
    input  logic             clear_cnt,
    output logic [CNT_W-1:0] conflict_count
);

    arb_state_t       state_reg, state_next;
    arb_req_t         latch_reg, latch_next;
    logic             abort_reg, abort_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;

    logic i_req, d_req;
    logic grant_i, grant_d, conflict;
    logic own_i, own_d, busy;

    assign i_req = i_bus.cyc & i_bus.stb;
    assign d_req = d_bus.cyc & d_bus.stb;

    l2_arbiter_rr u_rr (
        .clk      (clk),
        .rst      (rst),
        .arb_en   (state_reg == IDLE),
        .i_req    (i_req),
        .d_req    (d_req),
        .grant_i  (grant_i),
        .grant_d  (grant_d),
        .conflict (conflict)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            latch_reg <= '0;
            abort_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            latch_reg <= latch_next;
            abort_reg <= abort_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state, request latch and abort flag. The abort flag remembers that
    // the owner walked away; the L2 op still runs to its ack, which is then
    // swallowed even if the owner has raised cyc again in the meantime.
    always_comb begin
        state_next = state_reg;
        latch_next = latch_reg;
        abort_next = abort_reg;
        case (state_reg)
            IDLE: begin
                if (grant_i) begin
                    state_next = BUSY_I;
                    latch_next = pack_req(i_bus.we, i_bus.adr, i_bus.sel, i_bus.dat_m);
                end else if (grant_d) begin
                    state_next = BUSY_D;
                    latch_next = pack_req(d_bus.we, d_bus.adr, d_bus.sel, d_bus.dat_m);
                end
            end
            BUSY_I: begin
                if (l2_bus.ack) begin
                    state_next = IDLE;
                    abort_next = 1'b0;
                end else if (!i_bus.cyc) begin
                    abort_next = 1'b1;
                end
            end
            BUSY_D: begin
                if (l2_bus.ack) begin
                    state_next = IDLE;
                    abort_next = 1'b0;
                end else if (!d_bus.cyc) begin
                    abort_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                abort_next = 1'b0;
            end
        endcase
    end

    // Saturating conflict counter; a clear in the same cycle wins.
    always_comb begin
        cnt_next = cnt_reg;
        if (clear_cnt) begin
            cnt_next = '0;
        end else if (conflict && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign own_i = ~rst & (state_reg == BUSY_I);
    assign own_d = ~rst & (state_reg == BUSY_D);
    assign busy  = own_i | own_d;

    // L2 side is driven only from the latch, never from the live requester.
    assign l2_bus.cyc   = busy;
    assign l2_bus.stb   = busy;
    assign l2_bus.we    = busy & latch_reg.we;
    assign l2_bus.adr   = busy ? latch_reg.adr   : '0;
    assign l2_bus.sel   = busy ? latch_reg.sel   : '0;
    assign l2_bus.dat_m = busy ? latch_reg.dat_m : '0;

    assign i_bus.ack    = own_i & l2_bus.ack & i_bus.cyc & ~abort_reg;
    assign d_bus.ack    = own_d & l2_bus.ack & d_bus.cyc & ~abort_reg;
    assign i_bus.dat_s  = own_i ? l2_bus.dat_s : '0;
    assign d_bus.dat_s  = own_d ? l2_bus.dat_s : '0;

    assign conflict_count = rst ? '0 : cnt_reg;

endmodule

// File: tb/tb_l2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_arbiter
// Directed scenarios followed by a randomized phase, all checked every cycle
// against a transaction-level model of the arbiter. The counter is built
// narrow here so that saturation is reachable in a few dozen cycles.
// ---------------------------------------------------------------------------
module tb_l2_arbiter;
    import l2_arbiter_pkg::*;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                clear_cnt;
    logic [TB_CNT_W-1:0] conflict_count;

    l2_arbiter_if ib();
    l2_arbiter_if db();
    l2_arbiter_if lb();

    l2_arbiter #(.CNT_W(TB_CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_bus          (ib),
        .d_bus          (db),
        .l2_bus         (lb),
        .clear_cnt      (clear_cnt),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who owns the L2 port (0 none, 1 I, 2 D), the captured request,
    // whether the last tie went to D, whether the owner abandoned, the count.
    int                m_owner;
    bit                m_last_d;
    bit                m_abort;
    int                m_cnt;
    bit                m_we;
    bit [ADDR_W-1:0]   m_adr;
    bit [SEL_W-1:0]    m_sel;
    bit [LINE_W-1:0]   m_dat;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_last_d = 1'b1;
        m_abort  = 1'b0;
        m_cnt    = 0;
        m_we     = 1'b0;
        m_adr    = '0;
        m_sel    = '0;
        m_dat    = '0;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        ib.cyc = 0; ib.stb = 0; ib.we = 0; ib.adr = '0; ib.sel = '0; ib.dat_m = '0;
        db.cyc = 0; db.stb = 0; db.we = 0; db.adr = '0; db.sel = '0; db.dat_m = '0;
    endtask

    // Called at a negedge with inputs already driven: checks every output,
    // advances the model with the inputs the DUT will see at the next posedge.
    task automatic tick();
        bit busy, i_own, d_own, i_rq, d_rq, tie, exp_ack;
        int win;
        #1;
        busy  = !rst && (m_owner != 0);
        i_own = !rst && (m_owner == 1);
        d_own = !rst && (m_owner == 2);
        chk("l2_cyc",   lb.cyc,   busy);
        chk("l2_stb",   lb.stb,   busy);
        chk("l2_we",    lb.we,    busy && m_we);
        chk("l2_adr",   lb.adr,   busy ? m_adr : '0);
        chk("l2_sel",   lb.sel,   busy ? m_sel : '0);
        chk("l2_dat_m", lb.dat_m, busy ? m_dat : '0);
        chk("i_ack",    ib.ack,   i_own && lb.ack && ib.cyc && !m_abort);
        chk("i_dat_s",  ib.dat_s, i_own ? lb.dat_s : '0);
        chk("d_ack",    db.ack,   d_own && lb.ack && db.cyc && !m_abort);
        chk("d_dat_s",  db.dat_s, d_own ? lb.dat_s : '0);
        chk("conflict_count", conflict_count, rst ? 0 : m_cnt);

        if (busy && lb.ack) begin
            exp_ack = !m_abort && (m_owner == 1 ? ib.cyc : db.cyc);
            $display("txn %s we=%0b adr=%03h sel=%04h delivered=%0b",
                     (m_owner == 1) ? "I" : "D", m_we, m_adr, m_sel, exp_ack);
        end

        if (rst) begin
            model_reset();
        end else begin
            i_rq = ib.cyc && ib.stb;
            d_rq = db.cyc && db.stb;
            tie  = (m_owner == 0) && i_rq && d_rq;
            if (clear_cnt) m_cnt = 0;
            else if (tie && m_cnt < CNT_MAX) m_cnt++;
            if (m_owner == 0) begin
                if (tie) begin
                    win = m_last_d ? 1 : 2;
                    m_last_d = (win == 2);
                end else if (i_rq) win = 1;
                else if (d_rq)     win = 2;
                else               win = 0;
                if (win == 1) begin
                    m_we = ib.we; m_adr = ib.adr; m_sel = ib.sel; m_dat = ib.dat_m;
                end else if (win == 2) begin
                    m_we = db.we; m_adr = db.adr; m_sel = db.sel; m_dat = db.dat_m;
                end
                m_owner = win;
            end else if (lb.ack) begin
                m_owner = 0;
                m_abort = 1'b0;
            end else if ((m_owner == 1 && !ib.cyc) || (m_owner == 2 && !db.cyc)) begin
                m_abort = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [LINE_W-1:0] wdat;

    initial begin
        rst = 1; clear_cnt = 0;
        idle_inputs();
        lb.ack = 0; lb.dat_s = '0;
        model_reset();
        @(negedge clk);
        tick(); tick();
        rst = 0;
        tick();

        // 1: lone I read, L2 acks three cycles after stb
        ib.cyc = 1; ib.stb = 1; ib.we = 0; ib.adr = 12'h0A1; ib.sel = 16'hFFFF; ib.dat_m = rand_line();
        lb.dat_s = {4{32'hDEADBEEF}};
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t1_l2_adr", lb.adr, 12'h0A1);
            chk("t1_i_ack_wait", ib.ack, 1'b0);
            tick();
        end
        lb.ack = 1;
        #1;
        chk("t1_i_ack", ib.ack, 1'b1);
        chk("t1_i_dat", ib.dat_s, {4{32'hDEADBEEF}});
        chk("t1_d_ack", db.ack, 1'b0);
        tick();
        lb.ack = 0; ib.cyc = 0; ib.stb = 0;
        #1;
        chk("t1_idle_cyc", lb.cyc, 1'b0);
        tick();

        // 2a: both from reset, I drops after its ack
        rst = 1; tick(); rst = 0;
        ib.cyc = 1; ib.stb = 1; ib.adr = 12'h111;
        db.cyc = 1; db.stb = 1; db.adr = 12'h222;
        tick();
        lb.ack = 1;
        #1;
        chk("t2_first_is_i", lb.adr, 12'h111);
        chk("t2_i_ack", ib.ack, 1'b1);
        tick();
        ib.cyc = 0; ib.stb = 0; lb.ack = 0;
        tick();
        lb.ack = 1;
        #1;
        chk("t2_then_d", lb.adr, 12'h222);
        chk("t2_d_ack", db.ack, 1'b1);
        tick();
        lb.ack = 0; db.cyc = 0; db.stb = 0;
        #1;
        chk("t2_cnt_one", conflict_count, 1);
        tick();

        // 2b: both from reset, I keeps stb high after its ack
        rst = 1; tick(); rst = 0;
        ib.cyc = 1; ib.stb = 1; db.cyc = 1; db.stb = 1;
        tick();
        lb.ack = 1; tick();
        lb.ack = 0; tick();
        #1;
        chk("t2b_d_second", lb.adr, 12'h222);
        chk("t2b_cnt_two", conflict_count, 2);
        lb.ack = 1; tick();
        lb.ack = 0; idle_inputs(); tick();

        // 3: D write, requester scribbles on its inputs while busy
        wdat = rand_line();
        db.cyc = 1; db.stb = 1; db.we = 1; db.adr = 12'h3C3; db.sel = 16'h0030; db.dat_m = wdat;
        tick();
        for (int k = 0; k < 3; k++) begin
            db.adr = 12'($urandom); db.sel = 16'($urandom); db.dat_m = rand_line(); db.we = 0;
            #1;
            chk("t3_dat_m_held", lb.dat_m, wdat);
            chk("t3_sel_held", lb.sel, 16'h0030);
            chk("t3_we_held", lb.we, 1'b1);
            tick();
        end
        lb.ack = 1; tick();
        lb.ack = 0; idle_inputs(); tick();

        // 4: D abandons one cycle after grant, then raises cyc again before ack
        db.cyc = 1; db.stb = 1; db.adr = 12'h444;
        tick();
        db.cyc = 0; db.stb = 0;
        #1;
        chk("t4_stb_held", lb.stb, 1'b1);
        tick();
        db.cyc = 1; db.stb = 0;
        tick();
        lb.ack = 1;
        #1;
        chk("t4_ack_suppressed", db.ack, 1'b0);
        chk("t4_stb_at_ack", lb.stb, 1'b1);
        tick();
        lb.ack = 0; db.cyc = 0;
        #1;
        chk("t4_idle", lb.cyc, 1'b0);
        tick();

        // 5: reset while BUSY_I
        ib.cyc = 1; ib.stb = 1; ib.adr = 12'h555;
        tick(); tick();
        rst = 1;
        #1;
        chk("t5_cyc_in_rst", lb.cyc, 1'b0);
        tick();
        rst = 0; db.cyc = 1; db.stb = 1; db.adr = 12'h666;
        #1;
        chk("t5_cyc_after", lb.cyc, 1'b0);
        chk("t5_i_ack_after", ib.ack, 1'b0);
        chk("t5_cnt_after", conflict_count, 0);
        tick();
        lb.ack = 1;
        #1;
        chk("t5_i_wins_tie", lb.adr, 12'h555);
        tick();
        lb.ack = 0; idle_inputs(); tick();

        // 6: saturation, then clear racing a conflict
        ib.cyc = 1; ib.stb = 1; db.cyc = 1; db.stb = 1; lb.ack = 1;
        for (int k = 0; k < 2 * CNT_MAX + 6; k++) tick();
        #1;
        chk("t6_saturated", conflict_count, CNT_MAX);
        for (int k = 0; k < 4 && m_owner != 0; k++) tick();
        clear_cnt = 1;
        tick();
        clear_cnt = 0;
        #1;
        chk("t6_clear_wins", conflict_count, 0);
        tick();
        lb.ack = 0; idle_inputs(); tick(); tick();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            ib.cyc = ($urandom_range(0, 3) != 0); ib.stb = 1'($urandom_range(0, 1));
            ib.we = 1'($urandom); ib.adr = 12'($urandom); ib.sel = 16'($urandom); ib.dat_m = rand_line();
            db.cyc = ($urandom_range(0, 3) != 0); db.stb = 1'($urandom_range(0, 1));
            db.we = 1'($urandom); db.adr = 12'($urandom); db.sel = 16'($urandom); db.dat_m = rand_line();
            lb.ack = ($urandom_range(0, 2) == 0);
            lb.dat_s = rand_line();
            clear_cnt = ($urandom_range(0, 30) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0; clear_cnt = 0; lb.ack = 0; idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
